afe_config_sequencer: RTL and testbench

- Walks the AFE command ROM from address 0 and serializes each valid 20-bit entry to the AFE over a mode-0 SPI link.
- Sits between the command ROM (registered read, one-cycle latency) and the AFE SPI pins.
- Stops on a stop entry, on an invalid opcode, or after the last address.

---
 rtl/afe_cfg_pkg.sv | 21 ++
 rtl/afe_spi_shifter.sv | 79 +++++++
 rtl/afe_config_sequencer.sv | 177 +++++++++++++++++
 tb/tb_afe_config_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_cfg_pkg.sv
// Shared definitions for the AFE configuration sequencer: opcodes, field widths
// and the sequencer state encoding.
package afe_cfg_pkg;

    localparam int CMD_W  = 20;
    localparam int OP_W   = 4;
    localparam int ROM_AW = 8;

    localparam logic [OP_W-1:0] OP_STOP = 4'h0;
    localparam logic [OP_W-1:0] OP_SEND = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_GAP
    } seq_state_t;

endpackage

// File: rtl/afe_spi_shifter.sv
// Mode-0 SPI serializer: sclk generation, bit counter and MSB-first shift register.
// With AFE_READBACK_EN defined it also captures MISO on each rising sclk edge.
module afe_spi_shifter
    import afe_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CMD_W-1:0] payload_i,
`ifdef AFE_READBACK_EN
    input  logic             miso_i,
    output logic [CMD_W-1:0] rx_data_o,
`endif
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             frame_done_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic             active_q;
    logic             sclk_q;
    logic [CMD_W-1:0] shreg_q;
    logic [4:0]       bits_q;
    logic [DIV_W-1:0] div_q;
`ifdef AFE_READBACK_EN
    logic [CMD_W-1:0] rx_q;
    assign rx_data_o = rx_q;
`endif

    assign sclk_o = sclk_q;
    assign mosi_o = shreg_q[CMD_W-1];
    // Asserted on the edge that ends the last high phase, so the caller can start its hold timer in step.
    assign frame_done_o = active_q && sclk_q && (div_q == '0) && (bits_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            shreg_q  <= '0;
            bits_q   <= '0;
            div_q    <= '0;
`ifdef AFE_READBACK_EN
            rx_q     <= '0;
`endif
        end else if (load_i) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            shreg_q  <= payload_i;
            bits_q   <= 5'(CMD_W - 1);
            div_q    <= DIV_LOAD;
        end else if (active_q) begin
            if (div_q != '0) begin
                div_q <= div_q - DIV_W'(1);
            end else begin
                div_q  <= DIV_LOAD;
                sclk_q <= ~sclk_q;
`ifdef AFE_READBACK_EN
                if (!sclk_q) begin
                    rx_q <= {rx_q[CMD_W-2:0], miso_i};
                end
`endif
                if (sclk_q) begin
                    if (bits_q == '0) begin
                        active_q <= 1'b0;
                        shreg_q  <= '0;
                    end else begin
                        shreg_q <= {shreg_q[CMD_W-2:0], 1'b0};
                        bits_q  <= bits_q - 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/afe_config_sequencer.sv
// Walks the AFE command ROM from address 0 and sends each SEND entry as one SPI frame.
// Optional AFE_READBACK_EN adds MISO capture with readback_data/readback_valid outputs.
//
// state      | meaning
// IDLE       | waiting for start; rom_address holds its last value
// FETCH      | rom_address stable, ROM read in flight
// DECODE     | opcode examined: stop, send or error
// SHIFT      | cs_n low, 20 payload bits clocked out
// CS_HOLD    | cs_n still low for CLK_DIV cycles after the last sclk fall
// GAP        | cs_n high between frames, then next address or finish
module afe_config_sequencer
    import afe_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [ROM_AW-1:0]      rom_address,
    input  logic [OP_W+CMD_W-1:0]  rom_command,
    output logic                   spi_sclk,
    output logic                   spi_cs_n,
    output logic                   spi_mosi,
`ifdef AFE_READBACK_EN
    input  logic                   spi_miso,
    output logic [CMD_W-1:0]       readback_data,
    output logic                   readback_valid,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [8:0]             cmd_count
);

    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // FETCH, DECODE and the shifter load cycle also keep cs_n high, so GAP itself is shortened.
    localparam logic [TMR_W-1:0] GAP_LOAD  = (CS_GAP >= 2) ? TMR_W'(CS_GAP - 2) : '0;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(CLK_DIV - 1);

    seq_state_t        state_q;
    logic [ROM_AW-1:0] addr_q;
    logic [8:0]        cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cs_n_q;
    logic              load_q;
    logic [CMD_W-1:0]  payload_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              frame_done;
`ifdef AFE_READBACK_EN
    logic [CMD_W-1:0]  rx_data;
    logic [CMD_W-1:0]  rb_data_q;
    logic              rb_valid_q;
    assign readback_data  = rb_data_q;
    assign readback_valid = rb_valid_q;
`endif

    assign rom_address = addr_q;
    assign spi_cs_n    = cs_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign cmd_count   = cnt_q;

    afe_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load_q),
        .payload_i    (payload_q),
`ifdef AFE_READBACK_EN
        .miso_i       (spi_miso),
        .rx_data_o    (rx_data),
`endif
        .sclk_o       (spi_sclk),
        .mosi_o       (spi_mosi),
        .frame_done_o (frame_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            load_q    <= 1'b0;
            payload_q <= '0;
            tmr_q     <= '0;
`ifdef AFE_READBACK_EN
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            load_q <= 1'b0;
`ifdef AFE_READBACK_EN
            rb_valid_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        addr_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    case (rom_command[CMD_W +: OP_W])
                        OP_STOP: begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                        OP_SEND: begin
                            payload_q <= rom_command[CMD_W-1:0];
                            load_q    <= 1'b1;
                            state_q   <= ST_SHIFT;
                        end
                        default: begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
                ST_SHIFT: begin
                    // cs_n falls on the same edge the shifter takes the payload.
                    if (load_q) begin
                        cs_n_q <= 1'b0;
                    end
                    if (frame_done) begin
                        tmr_q   <= HOLD_LOAD;
                        state_q <= ST_CS_HOLD;
                    end
                end
                ST_CS_HOLD: begin
                    if (tmr_q == '0) begin
                        cs_n_q  <= 1'b1;
                        cnt_q   <= cnt_q + 9'd1;
                        tmr_q   <= GAP_LOAD;
                        state_q <= ST_GAP;
`ifdef AFE_READBACK_EN
                        rb_data_q  <= rx_data;
                        rb_valid_q <= 1'b1;
`endif
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end else if (addr_q == '1) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q  <= addr_q + ROM_AW'(1);
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Directed self-checking bench for afe_config_sequencer with a registered-read ROM model
// and a negedge bus monitor. Readback checks compile in when AFE_READBACK_EN is defined.
module tb_afe_config_sequencer;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 8;
    localparam int LOW_LEN = 41 * CLK_DIV;
    localparam int PERIOD  = 41 * CLK_DIV + CS_GAP + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_address;
    logic [23:0] rom_command = '0;
    logic        spi_sclk, spi_cs_n, spi_mosi, busy, done, error;
    logic [8:0]  cmd_count;
`ifdef AFE_READBACK_EN
    logic        spi_miso = 1'b0;
    logic [19:0] readback_data;
    logic        readback_valid;
    logic [19:0] rb_pat = 20'hABCDE;
    logic [20:0] rb_at_rise[$];
    int          rb_valid_cnt = 0;
`endif

    logic [23:0] rom [256];

    always #5 clk = ~clk;
    always @(posedge clk) rom_command <= rom[rom_address];

    afe_config_sequencer #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .rom_address    (rom_address),
        .rom_command    (rom_command),
        .spi_sclk       (spi_sclk),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
`ifdef AFE_READBACK_EN
        .spi_miso       (spi_miso),
        .readback_data  (readback_data),
        .readback_valid (readback_valid),
`endif
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cmd_count      (cmd_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // bus monitor, sampled on the falling clock edge
    logic [19:0] frames[$];
    int          lows[$];
    time         falls[$];
    int          done_cnt = 0;
    time         done_t = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [19:0] sh = '0;
    int          cur_bits = 0;
    int          low_len = 0;

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            falls.push_back($time);
            low_len  = 0;
            cur_bits = 0;
        end
        if (!spi_cs_n) low_len++;
        if (!prev_sclk && spi_sclk && !spi_cs_n) begin
            sh = {sh[18:0], spi_mosi};
            cur_bits++;
        end
        if (!prev_cs && spi_cs_n) begin
            frames.push_back(sh);
            lows.push_back(low_len);
`ifdef AFE_READBACK_EN
            rb_at_rise.push_back({readback_valid, readback_data});
`endif
        end
        if (done) begin
            done_cnt++;
            done_t = $time;
        end
`ifdef AFE_READBACK_EN
        if (readback_valid) rb_valid_cnt++;
        spi_miso = (!spi_cs_n && cur_bits < 20) ? rb_pat[19 - cur_bits] : 1'b0;
`endif
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    function automatic logic [19:0] frame_at(input int i);
        return (frames.size() > i) ? frames[i] : 20'hxxxxx;
    endfunction

    function automatic int low_at(input int i);
        return (lows.size() > i) ? lows[i] : -1;
    endfunction

    time t_start;

    task automatic clear_mon();
        frames.delete();
        lows.delete();
        falls.delete();
        done_cnt = 0;
`ifdef AFE_READBACK_EN
        rb_at_rise.delete();
        rb_valid_cnt = 0;
`endif
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        t_start = $time;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        rom_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);
`ifdef AFE_READBACK_EN
        chk("rst_rb_data", 32'(readback_data), 32'd0);
        chk("rst_rb_valid", 32'(readback_valid), 32'd0);
`endif

        // three frames then stop
        rom_clear();
        rom[0] = 24'h112345; rom[1] = 24'h1ABCDE; rom[2] = 24'h100001; rom[3] = 24'h000000;
        clear_mon();
        pulse_start();
        #1;
        chk("a_busy_after_start", 32'(busy), 32'd1);
        wait_idle("a_ends", 3000);
        chk("a_frames", 32'(frames.size()), 32'd3);
        chk("a_frame0", 32'(frame_at(0)), 32'h12345);
        chk("a_frame1", 32'(frame_at(1)), 32'hABCDE);
        chk("a_frame2", 32'(frame_at(2)), 32'h00001);
        for (int i = 0; i < 3; i++) chk("a_cs_low_len", 32'(low_at(i)), 32'(LOW_LEN));
        chk("a_first_fall_lat", (falls.size() > 0) ? 32'((falls[0] - t_start - 10) / 10) : 32'hFFFF, 32'd3);
        chk("a_period", (falls.size() > 1) ? 32'((falls[1] - falls[0]) / 10) : 32'hFFFF, 32'(PERIOD));
        chk("a_done_cnt", 32'(done_cnt), 32'd1);
        chk("a_cmd_count", 32'(cmd_count), 32'd3);
        chk("a_error", 32'(error), 32'd0);
        chk("a_rom_address", 32'(rom_address), 32'd3);
`ifdef AFE_READBACK_EN
        chk("a_rb_frame0", (rb_at_rise.size() > 0) ? 32'(rb_at_rise[0]) : 32'hFFFFFFFF, 32'h1ABCDE);
        chk("a_rb_valid_cnt", 32'(rb_valid_cnt), 32'd3);
`endif

        // stop entry at address 0
        rom_clear();
        clear_mon();
        pulse_start();
        wait_idle("b_ends", 50);
        chk("b_done_lat", 32'((done_t - t_start - 10) / 10), 32'd2);
        chk("b_done_cnt", 32'(done_cnt), 32'd1);
        chk("b_cs_falls", 32'(falls.size()), 32'd0);
        chk("b_cmd_count", 32'(cmd_count), 32'd0);

        // invalid opcode after one frame
        rom_clear();
        rom[0] = 24'h1FFFFF; rom[1] = 24'h2000AA;
        clear_mon();
        pulse_start();
        wait_idle("c_ends", 1000);
        chk("c_frames", 32'(frames.size()), 32'd1);
        chk("c_frame0", 32'(frame_at(0)), 32'hFFFFF);
        chk("c_error", 32'(error), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_done_cnt", 32'(done_cnt), 32'd0);
        chk("c_cmd_count", 32'(cmd_count), 32'd1);
        rom[0] = 24'h000000;
        pulse_start();
        #1;
        chk("c_error_cleared", 32'(error), 32'd0);
        wait_idle("c2_ends", 50);

        // start re-pulsed during frame 1 is ignored
        rom_clear();
        rom[0] = 24'h112345; rom[1] = 24'h1ABCDE; rom[2] = 24'h100001;
        clear_mon();
        pulse_start();
        begin
            int n = 0;
            while (falls.size() == 0 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("d_frame1_started", 32'(falls.size()), 32'd1);
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        wait_idle("d_ends", 3000);
        chk("d_cmd_count", 32'(cmd_count), 32'd3);
        chk("d_frames", 32'(frames.size()), 32'd3);
        chk("d_done_cnt", 32'(done_cnt), 32'd1);

        // reset at bit 10 of frame 2, then replay
        clear_mon();
        pulse_start();
        begin
            int n = 0;
            while (!(falls.size() == 2 && cur_bits == 10) && n < 1000) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("e_reached_bit10", 32'(falls.size() == 2 && cur_bits == 10), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("e_cs_n", 32'(spi_cs_n), 32'd1);
        chk("e_sclk", 32'(spi_sclk), 32'd0);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_cmd_count", 32'(cmd_count), 32'd0);
        chk("e_rom_address", 32'(rom_address), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        clear_mon();
        pulse_start();
        wait_idle("e_replay_ends", 3000);
        chk("e_replay_frames", 32'(frames.size()), 32'd3);
        chk("e_replay_frame0", 32'(frame_at(0)), 32'h12345);
        chk("e_replay_cmd_count", 32'(cmd_count), 32'd3);

        // full ROM of send entries: no wrap past 255
        for (int i = 0; i < 256; i++) rom[i] = 24'h100000 | 24'(i);
        clear_mon();
        pulse_start();
        wait_idle("f_ends", 256 * PERIOD + 200);
        chk("f_frames", 32'(frames.size()), 32'd256);
        chk("f_frame7", 32'(frame_at(7)), 32'h00007);
        chk("f_frame200", 32'(frame_at(200)), 32'h000C8);
        chk("f_frame255", 32'(frame_at(255)), 32'h000FF);
        chk("f_cmd_count", 32'(cmd_count), 32'd256);
        chk("f_rom_address", 32'(rom_address), 32'd255);
        chk("f_done_cnt", 32'(done_cnt), 32'd1);
        chk("f_error", 32'(error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
